// File: rtl/router_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : router_switch_allocator
// Purpose  : 5-port wormhole switch allocator. Each output locks to one input
//            for a whole packet; contenders are served round-robin.
// Revision : 1.0
// ============================================================================
module router_switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int SEL_W     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [NUM_PORTS*SEL_W-1:0] in_dest,
  input  logic [NUM_PORTS-1:0]       in_last,
  input  logic [NUM_PORTS-1:0]       out_full,
  output logic [NUM_PORTS-1:0]       in_read,
  output logic [NUM_PORTS-1:0]       out_write,
  output logic [NUM_PORTS*SEL_W-1:0] out_sel,
  output logic [NUM_PORTS-1:0]       out_busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t               state_q [NUM_PORTS];
  state_t               state_d [NUM_PORTS];
  logic [SEL_W-1:0]     sel_q   [NUM_PORTS];
  logic [SEL_W-1:0]     sel_d   [NUM_PORTS];
  logic [SEL_W-1:0]     rr_q    [NUM_PORTS];
  logic [SEL_W-1:0]     rr_d    [NUM_PORTS];
  logic [NUM_PORTS-1:0] req     [NUM_PORTS];
  logic [NUM_PORTS-1:0] xfer;
  logic [NUM_PORTS-1:0] rd;

  logic                 found;
  logic [SEL_W-1:0]     win;
  logic                 own_valid;
  logic                 own_last;
  logic [SEL_W-1:0]     own_dest;

  // req[o][i]: input i heads for output o; out-of-range destinations match nothing
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_req_out
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req_in
      assign req[o][i] = in_valid[i] && (in_dest[i*SEL_W +: SEL_W] == SEL_W'(o));
    end
  end

  always_comb begin
    rd        = '0;
    xfer      = '0;
    found     = 1'b0;
    win       = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_dest  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      sel_d[o]   = sel_q[o];
      rr_d[o]    = rr_q[o];
      found      = 1'b0;
      win        = '0;
      own_valid  = 1'b0;
      own_last   = 1'b0;
      own_dest   = '0;

      // Round-robin search starting at rr_q[o], wrapping past the top index
      for (int k = 0; k < NUM_PORTS; k++) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (!found && req[o][i] && (i == (int'(rr_q[o]) + k) % NUM_PORTS)) begin
            found = 1'b1;
            win   = SEL_W'(i);
          end
        end
      end

      for (int i = 0; i < NUM_PORTS; i++) begin
        if (sel_q[o] == SEL_W'(i)) begin
          own_valid = in_valid[i];
          own_last  = in_last[i];
          own_dest  = in_dest[i*SEL_W +: SEL_W];
        end
      end

      if (state_q[o] == S_IDLE) begin
        if (found) begin
          state_d[o] = S_LOCK;
          sel_d[o]   = win;
        end
      end else if (own_valid && (own_dest == SEL_W'(o)) && !out_full[o]) begin
        xfer[o] = 1'b1;
        rd      = rd | (NUM_PORTS'(1) << sel_q[o]);
        if (own_last) begin
          state_d[o] = S_IDLE;
          rr_d[o]    = (sel_q[o] == SEL_W'(NUM_PORTS-1)) ? '0 : sel_q[o] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= S_IDLE;
        sel_q[o]   <= '0;
        rr_q[o]    <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        sel_q[o]   <= sel_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

  assign in_read   = rd;
  assign out_write = xfer;

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    assign out_sel[o*SEL_W +: SEL_W] = sel_q[o];
    assign out_busy[o]               = (state_q[o] == S_LOCK);
  end

endmodule
`default_nettype wire

// File: tb/tb_router_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_switch_allocator
// Purpose  : Directed scoreboard bench for router_switch_allocator.
// Revision : 1.0
// ============================================================================
module tb_router_switch_allocator;

  logic        clk;
  logic        reset;
  logic [4:0]  in_valid;
  logic [14:0] in_dest;
  logic [4:0]  in_last;
  logic [4:0]  out_full;
  logic [4:0]  in_read;
  logic [4:0]  out_write;
  logic [14:0] out_sel;
  logic [4:0]  out_busy;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [4:0]  wr;
    logic [14:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  router_switch_allocator #(.NUM_PORTS(5), .SEL_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .out_full  (out_full),
    .in_read   (in_read),
    .out_write (out_write),
    .out_sel   (out_sel),
    .out_busy  (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] dst(input int d0, input int d1, input int d2,
                                      input int d3, input int d4);
    return {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle of inputs; queue the transfer expected in this cycle, if any
  task automatic step(input logic [4:0] v, input logic [14:0] d, input logic [4:0] l,
                      input logic [4:0] f, input logic [4:0] erd, input logic [4:0] ewr,
                      input logic [14:0] esel);
    exp_t e;
    in_valid = v;
    in_dest  = d;
    in_last  = l;
    out_full = f;
    if (ewr != 5'b0) begin
      e.cyc = cyc;
      e.rd  = erd;
      e.wr  = ewr;
      e.sel = esel;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with a read or write must match the next queued transfer
  always @(negedge clk) begin
    exp_t e;
    if (in_read != 5'b0 || out_write != 5'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer_wr", 32'(out_write), 0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_cycle", 32'(cyc), 32'(e.cyc));
        chk("xfer_in_read", 32'(in_read), 32'(e.rd));
        chk("xfer_out_write", 32'(out_write), 32'(e.wr));
        for (int o = 0; o < 5; o++) begin
          if (e.wr[o]) chk("xfer_out_sel", 32'(out_sel[o*3 +: 3]), 32'(e.sel[o*3 +: 3]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [14:0] d;
    reset    = 1'b0;
    in_valid = 5'h1F;
    in_dest  = '0;
    in_last  = '0;
    out_full = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_read", 32'(in_read), 0);
    chk("rst_out_write", 32'(out_write), 0);
    chk("rst_out_busy", 32'(out_busy), 0);
    chk("rst_out_sel", 32'(out_sel), 0);

    // Single packet local -> east, three flits, grant on the first edge after release
    d = dst(3, 0, 0, 0, 0);
    in_valid = '0;
    reset    = 1'b1;
    step(5'h01, d, 5'h00, 5'h00, 5'h00, 5'h00, '0);
    chk("single_busy", 32'(out_busy), 'h08);
    step(5'h01, d, 5'h00, 5'h00, 5'h01, 5'h08, dst(0, 0, 0, 0, 0));
    step(5'h01, d, 5'h00, 5'h00, 5'h01, 5'h08, dst(0, 0, 0, 0, 0));
    step(5'h01, d, 5'h01, 5'h00, 5'h01, 5'h08, dst(0, 0, 0, 0, 0));
    chk("single_busy_after_tail", 32'(out_busy), 0);

    // Contention north/west -> local, then rotation back to north
    d = dst(0, 0, 0, 0, 0);
    step(5'h12, d, 5'h00, 5'h00, 5'h00, 5'h00, '0);
    chk("cont_busy", 32'(out_busy), 'h01);
    chk("cont_sel_north", 32'(out_sel[2:0]), 1);
    step(5'h12, d, 5'h00, 5'h00, 5'h02, 5'h01, dst(1, 0, 0, 0, 0));
    step(5'h12, d, 5'h02, 5'h00, 5'h02, 5'h01, dst(1, 0, 0, 0, 0));
    chk("cont_bubble_busy", 32'(out_busy), 0);
    step(5'h12, d, 5'h00, 5'h00, 5'h00, 5'h00, '0);
    chk("cont_sel_west", 32'(out_sel[2:0]), 4);
    step(5'h12, d, 5'h10, 5'h00, 5'h10, 5'h01, dst(4, 0, 0, 0, 0));
    step(5'h12, d, 5'h00, 5'h00, 5'h00, 5'h00, '0);
    chk("cont_sel_north_again", 32'(out_sel[2:0]), 1);
    step(5'h02, d, 5'h02, 5'h00, 5'h02, 5'h01, dst(1, 0, 0, 0, 0));
    chk("cont_busy_end", 32'(out_busy), 0);

    // Backpressure local -> north, four stalled cycles mid-packet
    d = dst(1, 0, 0, 0, 0);
    step(5'h01, d, 5'h00, 5'h00, 5'h00, 5'h00, '0);
    step(5'h01, d, 5'h00, 5'h00, 5'h01, 5'h02, dst(0, 0, 0, 0, 0));
    for (int n = 0; n < 4; n++) step(5'h01, d, 5'h00, 5'h02, 5'h00, 5'h00, '0);
    chk("bp_busy_held", 32'(out_busy), 'h02);
    step(5'h01, d, 5'h01, 5'h00, 5'h01, 5'h02, dst(0, 0, 0, 0, 0));
    chk("bp_busy_end", 32'(out_busy), 0);

    // Parallel local -> north and west -> south
    d = dst(1, 0, 0, 0, 2);
    step(5'h11, d, 5'h00, 5'h00, 5'h00, 5'h00, '0);
    chk("par_busy", 32'(out_busy), 'h06);
    step(5'h11, d, 5'h00, 5'h00, 5'h11, 5'h06, dst(0, 0, 4, 0, 0));
    step(5'h11, d, 5'h11, 5'h00, 5'h11, 5'h06, dst(0, 0, 4, 0, 0));
    chk("par_busy_end", 32'(out_busy), 0);

    // Out-of-range destinations on east are never granted
    for (int n = 0; n < 4; n++) begin
      in_valid = 5'h08;
      in_dest  = dst(0, 0, 0, (n < 2) ? 5 : 7, 0);
      in_last  = 5'h08;
      out_full = '0;
      #1;
      chk("inv_in_read", 32'(in_read), 0);
      @(posedge clk);
      #1;
      chk("inv_busy", 32'(out_busy), 0);
    end

    // Reset mid-packet north -> east; afterwards local wins from rr_ptr 0
    d = dst(0, 3, 0, 0, 0);
    step(5'h02, d, 5'h00, 5'h00, 5'h00, 5'h00, '0);
    chk("abort_busy", 32'(out_busy), 'h08);
    chk("abort_sel_north", 32'(out_sel[11:9]), 1);
    step(5'h02, d, 5'h00, 5'h00, 5'h02, 5'h08, dst(0, 0, 0, 1, 0));
    reset = 1'b0;
    #1;
    chk("abort_busy_async", 32'(out_busy), 0);
    chk("abort_in_read", 32'(in_read), 0);
    chk("abort_out_write", 32'(out_write), 0);
    @(posedge clk);
    #1;
    d = dst(3, 3, 0, 0, 0);
    in_valid = 5'h03;
    in_dest  = d;
    reset    = 1'b1;
    step(5'h03, d, 5'h01, 5'h00, 5'h00, 5'h00, '0);
    chk("restart_sel_local", 32'(out_sel[11:9]), 0);
    chk("restart_busy", 32'(out_busy), 'h08);
    step(5'h03, d, 5'h01, 5'h00, 5'h01, 5'h08, dst(0, 0, 0, 0, 0));
    step(5'h00, d, 5'h00, 5'h00, 5'h00, 5'h00, '0);
    chk("restart_busy_end", 32'(out_busy), 0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
